// File: rtl/pu_tag_lookup_engine.sv
// Tag lookup engine: takes one PU request of 1..8 tags, reads the tag table with a bounded
// number of reads in flight, and writes one result per tag followed by one status per request.
module pu_tag_lookup_engine #(
    parameter int NUM_OF_PU       = 16,
    parameter int PU_ID_NBITS     = $clog2(NUM_OF_PU),
    parameter int RCI_NBITS       = 16,
    parameter int TAG_NBITS       = 16,
    parameter int MAX_TAGS        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PU_ID_NBITS-1:0]        req_pid,
    input  logic [3:0]                    req_tag_cnt,
    input  logic [MAX_TAGS*TAG_NBITS-1:0] req_tags,
    output logic                          tbl_rd,
    output logic [TAG_NBITS-1:0]          tbl_key,
    input  logic                          tbl_rsp_valid,
    input  logic                          tbl_rsp_hit,
    input  logic [RCI_NBITS-1:0]          tbl_rsp_rci,
    output logic                          tag_lookup_valid,
    output logic [RCI_NBITS-1:0]          tag_lookup_result,
    output logic [2:0]                    tag_lookup_result_num,
    output logic [PU_ID_NBITS-1:0]        tag_lookup_result_pid,
    output logic                          tag_lookup_status_valid,
    output logic [3:0]                    tag_lookup_status,
    output logic [PU_ID_NBITS-1:0]        tag_lookup_status_pid
);

    localparam int                   IDX_NBITS = $clog2(MAX_TAGS);
    localparam int                   OUT_NBITS = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0]           MAX_CNT   = 4'(MAX_TAGS);
    localparam logic [OUT_NBITS-1:0] OUT_LIMIT = OUT_NBITS'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, STATUS} state_t;

    state_t                 state_reg, state_next;
    logic [PU_ID_NBITS-1:0] pid_reg;
    logic [3:0]             cnt_reg;
    logic [3:0]             issue_idx_reg;
    logic [3:0]             rsp_idx_reg;
    logic                   miss_reg;
    logic [OUT_NBITS-1:0]   outstanding_reg;
    logic [TAG_NBITS-1:0]   req_tag_arr [MAX_TAGS];
    logic [TAG_NBITS-1:0]   tags_reg    [MAX_TAGS];

    logic                   req_ready_reg;
    logic                   tbl_rd_reg;
    logic [TAG_NBITS-1:0]   tbl_key_reg;
    logic                   result_valid_reg;
    logic [RCI_NBITS-1:0]   result_reg;
    logic [2:0]             result_num_reg;
    logic [PU_ID_NBITS-1:0] result_pid_reg;
    logic                   status_valid_reg;
    logic [3:0]             status_reg;
    logic [PU_ID_NBITS-1:0] status_pid_reg;

    logic                   req_accept;
    logic                   req_bad;
    logic                   issue_fire;
    logic                   rsp_accept;
    logic                   last_issue;
    logic                   status_fire;
    logic [3:0]             status_next;
    logic [PU_ID_NBITS-1:0] status_pid_next;

    assign req_accept = (state_reg == IDLE) && req_valid && req_ready_reg;
    assign req_bad    = (req_tag_cnt == 4'd0) || (req_tag_cnt > MAX_CNT);
    assign issue_fire = (state_reg == ISSUE) && (outstanding_reg < OUT_LIMIT);
    // Responses with nothing in flight are stale (e.g. from before a reset) and are dropped.
    assign rsp_accept = tbl_rsp_valid && (outstanding_reg != '0);
    assign last_issue = (issue_idx_reg == (cnt_reg - 4'd1));

    generate
        for (genvar gi = 0; gi < MAX_TAGS; gi++) begin : g_tags
            assign req_tag_arr[gi] = req_tags[gi*TAG_NBITS +: TAG_NBITS];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    tags_reg[gi] <= '0;
                end else if (req_accept) begin
                    tags_reg[gi] <= req_tag_arr[gi];
                end
            end
        end
    endgenerate

    // Status is registered on the transition into STATUS so it lands one cycle after the last result.
    always_comb begin
        state_next      = state_reg;
        status_fire     = 1'b0;
        status_next     = 4'b0000;
        status_pid_next = pid_reg;
        case (state_reg)
            IDLE: begin
                if (req_accept) begin
                    if (req_bad) begin
                        state_next      = STATUS;
                        status_fire     = 1'b1;
                        status_next     = 4'b0101;
                        status_pid_next = req_pid;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_fire && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_idx_reg == cnt_reg) begin
                    state_next  = STATUS;
                    status_fire = 1'b1;
                    status_next = {2'b00, miss_reg, 1'b1};
                end
            end
            STATUS: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            pid_reg         <= '0;
            cnt_reg         <= '0;
            issue_idx_reg   <= '0;
            rsp_idx_reg     <= '0;
            miss_reg        <= 1'b0;
            outstanding_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (req_accept) begin
                pid_reg <= req_pid;
                cnt_reg <= req_tag_cnt;
            end
            if (req_accept) begin
                issue_idx_reg <= '0;
            end else if (issue_fire) begin
                issue_idx_reg <= issue_idx_reg + 4'd1;
            end
            if (req_accept) begin
                rsp_idx_reg <= '0;
            end else if (rsp_accept) begin
                rsp_idx_reg <= rsp_idx_reg + 4'd1;
            end
            if (req_accept) begin
                miss_reg <= 1'b0;
            end else if (rsp_accept && !tbl_rsp_hit) begin
                miss_reg <= 1'b1;
            end
            case ({issue_fire, rsp_accept})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready_reg    <= 1'b0;
            tbl_rd_reg       <= 1'b0;
            tbl_key_reg      <= '0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
            result_num_reg   <= '0;
            result_pid_reg   <= '0;
            status_valid_reg <= 1'b0;
            status_reg       <= '0;
            status_pid_reg   <= '0;
        end else begin
            req_ready_reg    <= (state_next == IDLE);
            tbl_rd_reg       <= issue_fire;
            result_valid_reg <= rsp_accept;
            status_valid_reg <= status_fire;
            if (issue_fire) begin
                tbl_key_reg <= tags_reg[issue_idx_reg[IDX_NBITS-1:0]];
            end
            if (rsp_accept) begin
                result_reg     <= tbl_rsp_hit ? tbl_rsp_rci : '0;
                result_num_reg <= rsp_idx_reg[2:0];
                result_pid_reg <= pid_reg;
            end
            if (status_fire) begin
                status_reg     <= status_next;
                status_pid_reg <= status_pid_next;
            end
        end
    end

    assign req_ready               = req_ready_reg;
    assign tbl_rd                  = tbl_rd_reg;
    assign tbl_key                 = tbl_key_reg;
    assign tag_lookup_valid        = result_valid_reg;
    assign tag_lookup_result       = result_reg;
    assign tag_lookup_result_num   = result_num_reg;
    assign tag_lookup_result_pid   = result_pid_reg;
    assign tag_lookup_status_valid = status_valid_reg;
    assign tag_lookup_status       = status_reg;
    assign tag_lookup_status_pid   = status_pid_reg;

endmodule

// File: tb/tb_pu_tag_lookup_engine.sv
// Scoreboard bench for pu_tag_lookup_engine: directed requests, fixed-latency table model,
// and a monitor that pops expected results/status as the engine writes them.
module tb_pu_tag_lookup_engine;

    localparam int PID_W = 4;
    localparam int RCI_W = 16;
    localparam int TAG_W = 16;
    localparam int MT    = 8;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               req_valid;
    logic               req_ready;
    logic [PID_W-1:0]   req_pid;
    logic [3:0]         req_tag_cnt;
    logic [MT*TAG_W-1:0] req_tags;
    logic               tbl_rd;
    logic [TAG_W-1:0]   tbl_key;
    logic               tbl_rsp_valid;
    logic               tbl_rsp_hit;
    logic [RCI_W-1:0]   tbl_rsp_rci;
    logic               tag_lookup_valid;
    logic [RCI_W-1:0]   tag_lookup_result;
    logic [2:0]         tag_lookup_result_num;
    logic [PID_W-1:0]   tag_lookup_result_pid;
    logic               tag_lookup_status_valid;
    logic [3:0]         tag_lookup_status;
    logic [PID_W-1:0]   tag_lookup_status_pid;

    always #5 clk = ~clk;

    pu_tag_lookup_engine #(
        .NUM_OF_PU(16), .PU_ID_NBITS(PID_W), .RCI_NBITS(RCI_W),
        .TAG_NBITS(TAG_W), .MAX_TAGS(MT), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_pid(req_pid),
        .req_tag_cnt(req_tag_cnt), .req_tags(req_tags),
        .tbl_rd(tbl_rd), .tbl_key(tbl_key),
        .tbl_rsp_valid(tbl_rsp_valid), .tbl_rsp_hit(tbl_rsp_hit), .tbl_rsp_rci(tbl_rsp_rci),
        .tag_lookup_valid(tag_lookup_valid), .tag_lookup_result(tag_lookup_result),
        .tag_lookup_result_num(tag_lookup_result_num), .tag_lookup_result_pid(tag_lookup_result_pid),
        .tag_lookup_status_valid(tag_lookup_status_valid), .tag_lookup_status(tag_lookup_status),
        .tag_lookup_status_pid(tag_lookup_status_pid)
    );

    typedef struct packed {
        logic             is_status;
        logic [RCI_W-1:0] val;
        logic [2:0]       num;
        logic [PID_W-1:0] pid;
    } exp_t;

    typedef struct packed {
        logic [TAG_W-1:0] key;
        int               due;
    } pend_t;

    exp_t  expq[$];
    pend_t pend[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    tbl_lat = 2;
    int    rd_count = 0;
    int    max_inflight = 0;
    int    last_rd_cyc = 0;
    int    last_res_cyc = 0;
    int    last_stat_cyc = 0;
    int    res_seen = 0;
    int    stat_seen = 0;
    logic [TAG_W-1:0] tv [MT];
    logic [RCI_W-1:0] rv [MT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Table contents: keys with top nibble F miss; 0x00A5 maps to 0x0012; others to key+0x1000.
    function automatic logic tbl_hit_of(input logic [TAG_W-1:0] key);
        return key[15:12] != 4'hF;
    endfunction

    function automatic logic [RCI_W-1:0] tbl_rci_of(input logic [TAG_W-1:0] key);
        return (key == 16'h00A5) ? 16'h0012 : key + 16'h1000;
    endfunction

    // Fixed-latency, in-order table model; deliberately not reset with the DUT.
    initial begin
        pend_t p;
        int    rsp_now;
        int    inflight;
        tbl_rsp_valid = 1'b0;
        tbl_rsp_hit   = 1'b0;
        tbl_rsp_rci   = '0;
        forever begin
            @(posedge clk);
            #1;
            tbl_rsp_valid = 1'b0;
            tbl_rsp_hit   = 1'b0;
            tbl_rsp_rci   = '0;
            rsp_now       = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p             = pend.pop_front();
                tbl_rsp_valid = 1'b1;
                tbl_rsp_hit   = tbl_hit_of(p.key);
                tbl_rsp_rci   = tbl_hit_of(p.key) ? tbl_rci_of(p.key) : 16'hDEAD;
                rsp_now       = 1;
            end
            if (tbl_rd) begin
                pend.push_back('{key: tbl_key, due: cyc + tbl_lat});
                rd_count++;
                last_rd_cyc = cyc;
            end
            inflight = pend.size() + rsp_now;
            if (inflight > max_inflight) max_inflight = inflight;
        end
    end

    // Monitor: pops the scoreboard whenever a result or status write appears.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tag_lookup_valid || tag_lookup_status_valid)
                chk("no_collision", {31'd0, tag_lookup_valid && tag_lookup_status_valid}, 32'd0);
            if (tag_lookup_valid) begin
                res_seen++;
                last_res_cyc = cyc;
                $display("result  pid=%0d num=%0d rci=0x%04h cycle=%0d",
                         tag_lookup_result_pid, tag_lookup_result_num, tag_lookup_result, cyc);
                if (expq.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("result", {8'd0, 1'b0, tag_lookup_result, tag_lookup_result_num, tag_lookup_result_pid},
                        {8'd0, e});
                end
            end
            if (tag_lookup_status_valid) begin
                stat_seen++;
                last_stat_cyc = cyc;
                $display("status  pid=%0d status=0x%0h cycle=%0d",
                         tag_lookup_status_pid, tag_lookup_status, cyc);
                if (expq.size() == 0) begin
                    chk("unexpected_status", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("status", {8'd0, 1'b1, 12'd0, tag_lookup_status, 3'd0, tag_lookup_status_pid},
                        {8'd0, e});
                end
            end
        end
    end

    // Pushes the hand-computed expectations from rv[], then presents the request and waits for
    // the accepting edge. req_valid stays high on return so requests can be chained.
    task automatic send(input logic [PID_W-1:0] pid, input logic [3:0] cnt,
                        input logic [3:0] exp_st, output int acc);
        int n_res;
        int t;
        n_res = (cnt >= 4'd1 && cnt <= 4'd8) ? int'(cnt) : 0;
        for (int i = 0; i < n_res; i++)
            expq.push_back('{is_status: 1'b0, val: rv[i], num: 3'(i), pid: pid});
        expq.push_back('{is_status: 1'b1, val: {12'd0, exp_st}, num: 3'd0, pid: pid});
        req_valid   = 1'b1;
        req_pid     = pid;
        req_tag_cnt = cnt;
        for (int i = 0; i < MT; i++) req_tags[i*TAG_W +: TAG_W] = tv[i];
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        $display("request pid=%0d cnt=%0d accepted cycle=%0d", pid, cnt, acc);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((expq.size() != 0 || pend.size() != 0 || !req_ready) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_timeout", {31'd0, t < 300}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_b;
        int rd0;
        int res0;
        int st0;
        int n;
        int t;
        req_valid   = 1'b0;
        req_pid     = '0;
        req_tag_cnt = '0;
        req_tags    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {27'd0, req_ready, tbl_rd, tag_lookup_valid, tag_lookup_status_valid, 1'b0}, 32'd0);
        chk("reset_status", {24'd0, tag_lookup_status, tag_lookup_result_num, 1'b0}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Single tag, L=2
        tbl_lat = 2;
        tv = '{16'h00A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        rv = '{16'h0012, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send(4'd3, 4'd1, 4'h1, acc);
        req_valid = 1'b0;
        wait_idle();
        chk("t1_rd_cycle", last_rd_cyc, acc + 1);
        chk("t1_result_cycle", last_res_cyc, acc + 4);
        chk("t1_status_cycle", last_stat_cyc, acc + 5);

        // Eight tags, L=6: credit limit must bind at exactly 4
        tbl_lat      = 6;
        max_inflight = 0;
        for (int i = 0; i < MT; i++) begin
            tv[i] = 16'h0100 + 16'(i);
            rv[i] = 16'h1100 + 16'(i);
        end
        send(4'd9, 4'd8, 4'h1, acc);
        req_valid = 1'b0;
        wait_idle();
        chk("t2_max_inflight", max_inflight, 4);

        // Four tags, tags 1 and 3 miss
        tbl_lat = 3;
        tv = '{16'h0031, 16'hF032, 16'h0033, 16'hF034, 16'h0, 16'h0, 16'h0, 16'h0};
        rv = '{16'h1031, 16'h0000, 16'h1033, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        send(4'd2, 4'd4, 4'h3, acc);
        req_valid = 1'b0;
        wait_idle();

        // Bad counts: 0 and 9 give status-only replies and no table reads
        rd0 = rd_count;
        send(4'd4, 4'd0, 4'h5, acc);
        req_valid = 1'b0;
        wait_idle();
        tv = '{16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045, 16'h0046, 16'h0047, 16'h0048};
        send(4'd10, 4'd9, 4'h5, acc);
        req_valid = 1'b0;
        wait_idle();
        chk("bad_cnt_no_reads", rd_count, rd0);

        // Back-to-back with req_valid held high
        tbl_lat = 1;
        tv = '{16'h0051, 16'h0052, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        rv = '{16'h1051, 16'h1052, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send(4'd5, 4'd2, 4'h1, acc);
        tv = '{16'hF061, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        rv = '{16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send(4'd6, 4'd1, 4'h3, acc_b);
        req_valid = 1'b0;
        chk("b2b_accept_after_status", acc_b, last_stat_cyc + 2);
        wait_idle();

        // Reset with two reads outstanding; late responses must be ignored
        tbl_lat     = 6;
        req_valid   = 1'b1;
        req_pid     = 4'd7;
        req_tag_cnt = 4'd4;
        for (int i = 0; i < MT; i++) req_tags[i*TAG_W +: TAG_W] = 16'h0071 + 16'(i);
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("request pid=7 cnt=4 accepted cycle=%0d (to be reset)", cyc);
        n = 0;
        t = 0;
        while (n < 2 && t < 30) begin
            @(posedge clk);
            #1;
            if (tbl_rd) n++;
            t++;
        end
        chk("rst_two_reads_issued", n, 2);
        rstn = 1'b0;
        #1;
        chk("rst_outputs_zero", {28'd0, req_ready, tbl_rd, tag_lookup_valid, tag_lookup_status_valid}, 32'd0);
        res0 = res_seen;
        st0  = stat_seen;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_after_release", {31'd0, req_ready}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_no_results", res_seen, res0);
        chk("rst_no_status", stat_seen, st0);
        wait_idle();

        chk("scoreboard_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_tag_lookup_engine.md
Name: pu_tag_lookup_engine

Overview:
- Producer side of the per-PU tag lookup result path.
- Accepts one tag lookup request at a time (PU id plus 1..8 tags) from the upstream PU request arbiter.
- Issues one table read per tag to the tag table, with pipelined, in-order responses and a credit limit.
- Emits one result write per tag, then one status write per request, on the tag_lookup_* interface consumed by the per-PU tag result memory.

Parameters:
NUM_OF_PU, `NUM_OF_PU, number of PUs; sizes the pid range
PU_ID_NBITS, `PU_ID_NBITS, pid width
RCI_NBITS, `RCI_NBITS, RCI result width
TAG_NBITS, 16, width of one tag key
MAX_TAGS, 8, max tags per request; fixed at 8 because result_num is 3 bits
MAX_OUTSTANDING, 4, max table reads in flight

Ports:
clk  in  1  clock
rstn  in  1  `RESET_SIG; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  engine idle and accepting
req_pid  in  PU_ID_NBITS  requesting PU
req_tag_cnt  in  4  number of tags; legal 1..8
req_tags  in  MAX_TAGS*TAG_NBITS  tag i in bits [i*TAG_NBITS +: TAG_NBITS]
tbl_rd  out  1  table read strobe
tbl_key  out  TAG_NBITS  key for tbl_rd
tbl_rsp_valid  in  1  table response; in order, latency >= 1
tbl_rsp_hit  in  1  key found
tbl_rsp_rci  in  RCI_NBITS  RCI on hit
tag_lookup_valid  out  1  result write
tag_lookup_result  out  RCI_NBITS  RCI; 0 on miss
tag_lookup_result_num  out  3  tag index 0..7
tag_lookup_result_pid  out  PU_ID_NBITS  target PU
tag_lookup_status_valid  out  1  status write
tag_lookup_status  out  4  [0] done=1, [1] any miss, [2] bad count, [3] 0
tag_lookup_status_pid  out  PU_ID_NBITS  target PU

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0, except req_ready, which is 1 one cycle after reset release.
  - FSM goes to IDLE; credit, issue and response counters clear.
- Registers: all outputs are registered.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch pid, cnt and tags; clear the miss flag. cnt in 1..8 -> ISSUE. cnt 0 or >8 -> STATUS with bad count set; no table reads.
  - ISSUE:
    - Assert tbl_rd with tbl_key=tag[issue_idx] when outstanding < MAX_OUTSTANDING.
    - issue_idx increments per tbl_rd.
    - After tbl_rd for index cnt-1 -> DRAIN.
    - Never exceed MAX_OUTSTANDING reads in flight; stall while at the limit.
  - DRAIN: wait for rsp_idx == cnt, i.e. the last result has been emitted -> STATUS.
  - STATUS: one cycle with tag_lookup_status_valid=1, status={0, bad, miss, 1} and status_pid=pid -> IDLE.
- Outstanding counter:
  - +1 on tbl_rd, -1 on tbl_rsp_valid.
  - Both in the same cycle: unchanged.
- Response handling (any state):
  - A tbl_rsp_valid with outstanding==0 is ignored.
  - Otherwise, one cycle later: tag_lookup_valid=1, result=hit ? rci : 0, result_num=rsp_idx[2:0], result_pid=pid.
  - rsp_idx then increments; the miss flag is set if hit=0.
- Status never coincides with a result: status fires at least one cycle after the last tag_lookup_valid. The consumer gives status priority, so a same-cycle pair would lose the result.
- Latency, request accepted at T with table latency L:
  - First tbl_rd at T+1.
  - First result at T+1+L+1.
  - Status one cycle after the last result.
  - req_ready returns the cycle after status.
- Result num range: result_num spans 0..cnt-1 with no wrap, because cnt <= 8.
- Reset mid-request:
  - The request is dropped; no status is emitted; outputs go to 0.
  - Late table responses after reset are ignored because outstanding == 0.

Test Plan:
- Single tag: pid=3, cnt=1, tag=0x00A5, table L=2 returns hit with rci=0x12. Required: tbl_rd at T+1; result (0x12, num 0, pid 3) at T+4; status 0x1, pid 3, at T+5.
- Eight tags, L=6, MAX_OUTSTANDING=4. Required: at most 4 reads in flight; results num 0..7 in order; one status after num 7; no cycle with result and status both valid.
- cnt=4, tags 1 and 3 miss. Required: results 1 and 3 carry RCI 0; status 0x3.
- Bad count: cnt=0, then cnt=9. Required: no tbl_rd; the status-only reply is 0x5 for each.
- Back-to-back requests with req_valid held high. Required: second request accepted only after the first status; pids are not mixed.
- Reset asserted with 2 reads outstanding, then 2 late tbl_rsp_valid pulses. Required: no tag_lookup_valid and no status; req_ready=1 after release.
